draw_paddles: RTL and testbench

- Second-generation paddle renderer for the VGA pipeline chain.
- Overlays two parametrised paddles (left/right) on an incoming background `rgb_in`.
- Paddle positions are latched once per frame, at vblank start, so a frame never tears. Each frame's movement is slew-limited and clamped to the screen.
- Sits between the background generator and the ball/score stages. Timing signals pass through with a fixed 2-cycle latency.

---
 rtl/pong_pkg.sv | 13 +
 rtl/paddle_tracker.sv | 54 +++++
 rtl/draw_paddles.sv | 205 ++++++++++++++++++++
 tb/tb_draw_paddles.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong VGA pipeline stages.
package pong_pkg;

  typedef logic [10:0] coord_t;
  typedef logic [11:0] rgb_t;

  localparam int unsigned H_RES_DEF = 1024;
  localparam int unsigned V_RES_DEF = 768;

  localparam rgb_t BLACK = 12'h000;
  localparam rgb_t WHITE = 12'hFFF;

endpackage

// File: rtl/paddle_tracker.sv
// Per-paddle center register: clamps the requested position to the screen and
// slew-limits the move on each frame update pulse.
module paddle_tracker
  import pong_pkg::*;
#(
  parameter int unsigned V_RES       = V_RES_DEF,
  parameter int unsigned PADDLE_HALF = 50,
  parameter int unsigned MAX_STEP    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_update,
  input  logic [10:0] i_pos,
  output logic [10:0] o_center
);

  localparam logic [11:0] LO   = 12'(PADDLE_HALF);
  localparam logic [11:0] HI   = 12'(V_RES - 1 - PADDLE_HALF);
  localparam logic [11:0] STEP = 12'(MAX_STEP);

  coord_t      r_center;
  logic [11:0] w_pos;
  logic [11:0] w_target;
  logic [11:0] w_cur;
  logic [11:0] w_next;

  always_comb begin
    w_pos = {1'b0, i_pos};
    w_cur = {1'b0, r_center};
    if (w_pos < LO) begin
      w_target = LO;
    end else if (w_pos > HI) begin
      w_target = HI;
    end else begin
      w_target = w_pos;
    end
    if (w_target >= w_cur) begin
      w_next = (w_target - w_cur <= STEP) ? w_target : w_cur + STEP;
    end else begin
      w_next = (w_cur - w_target <= STEP) ? w_target : w_cur - STEP;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_center <= 11'(V_RES / 2);
    end else if (i_update) begin
      r_center <= w_next[10:0];
    end
  end

  assign o_center = r_center;

endmodule

// File: rtl/draw_paddles.sv
// Two-stage paddle overlay on the VGA pipeline; centers are committed at vblank start.
// Optional PADDLE_OUTLINE_EN draws a white 1-pixel rim around each paddle.
module draw_paddles
  import pong_pkg::*;
#(
  parameter int unsigned H_RES        = H_RES_DEF,
  parameter int unsigned V_RES        = V_RES_DEF,
  parameter int unsigned PADDLE_HALF  = 50,
  parameter int unsigned PADDLE_WIDTH = 10,
  parameter int unsigned MARGIN       = 8,
  parameter int unsigned MAX_STEP     = 8,
  parameter logic [11:0] COLOR_L      = 12'hF00,
  parameter logic [11:0] COLOR_R      = 12'h00F
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] pos_l,
  input  logic [10:0] pos_r,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [10:0] center_l,
  output logic [10:0] center_r
);

  localparam logic [10:0] LX0  = 11'(MARGIN);
  localparam logic [10:0] LX1  = 11'(MARGIN + PADDLE_WIDTH - 1);
  localparam logic [10:0] RX0  = 11'(H_RES - MARGIN - PADDLE_WIDTH);
  localparam logic [10:0] RX1  = 11'(H_RES - MARGIN - 1);
  localparam logic [11:0] HALF = 12'(PADDLE_HALF);

  // Vertical span test without subtracting HALF from the center, so no top-of-screen underflow.
  function automatic logic in_span(input logic [10:0] v, input logic [10:0] c);
    logic [11:0] v12;
    logic [11:0] c12;
    v12 = {1'b0, v};
    c12 = {1'b0, c};
    return (v12 + HALF >= c12) && (v12 <= c12 + HALF);
  endfunction

  function automatic logic on_rim(input logic [10:0] h, input logic [10:0] x0,
                                  input logic [10:0] x1, input logic [10:0] v,
                                  input logic [10:0] c);
    logic [11:0] v12;
    logic [11:0] c12;
    v12 = {1'b0, v};
    c12 = {1'b0, c};
    return (h == x0) || (h == x1) || (v12 + HALF == c12) || (v12 == c12 + HALF);
  endfunction

  logic   r_vblnk_d;
  logic   r_armed;
  logic   w_update;
  coord_t w_center_l;
  coord_t w_center_r;

  // r_armed blocks a false pulse when reset is released in the middle of vblank.
  assign w_update = vblnk_in & ~r_vblnk_d & r_armed;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_vblnk_d <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_vblnk_d <= vblnk_in;
      r_armed   <= r_armed | ~vblnk_in;
    end
  end

  paddle_tracker #(
    .V_RES       (V_RES),
    .PADDLE_HALF (PADDLE_HALF),
    .MAX_STEP    (MAX_STEP)
  ) u_tracker_l (
    .i_clk    (pclk),
    .i_rst    (rst),
    .i_update (w_update),
    .i_pos    (pos_l),
    .o_center (w_center_l)
  );

  paddle_tracker #(
    .V_RES       (V_RES),
    .PADDLE_HALF (PADDLE_HALF),
    .MAX_STEP    (MAX_STEP)
  ) u_tracker_r (
    .i_clk    (pclk),
    .i_rst    (rst),
    .i_update (w_update),
    .i_pos    (pos_r),
    .o_center (w_center_r)
  );

  assign center_l = w_center_l;
  assign center_r = w_center_r;

  logic w_hit_l;
  logic w_hit_r;

  assign w_hit_l = (hcount_in >= LX0) && (hcount_in <= LX1) && in_span(vcount_in, w_center_l);
  assign w_hit_r = (hcount_in >= RX0) && (hcount_in <= RX1) && in_span(vcount_in, w_center_r);

  coord_t r_hcount1;
  coord_t r_vcount1;
  logic   r_hsync1;
  logic   r_hblnk1;
  logic   r_vsync1;
  logic   r_vblnk1;
  rgb_t   r_rgb1;
  logic   r_hit_l1;
  logic   r_hit_r1;
`ifdef PADDLE_OUTLINE_EN
  logic   r_edge_l1;
  logic   r_edge_r1;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_hcount1 <= '0;
      r_vcount1 <= '0;
      r_hsync1  <= 1'b0;
      r_hblnk1  <= 1'b0;
      r_vsync1  <= 1'b0;
      r_vblnk1  <= 1'b0;
      r_rgb1    <= BLACK;
      r_hit_l1  <= 1'b0;
      r_hit_r1  <= 1'b0;
`ifdef PADDLE_OUTLINE_EN
      r_edge_l1 <= 1'b0;
      r_edge_r1 <= 1'b0;
`endif
    end else begin
      r_hcount1 <= hcount_in;
      r_vcount1 <= vcount_in;
      r_hsync1  <= hsync_in;
      r_hblnk1  <= hblnk_in;
      r_vsync1  <= vsync_in;
      r_vblnk1  <= vblnk_in;
      r_rgb1    <= rgb_in;
      r_hit_l1  <= w_hit_l;
      r_hit_r1  <= w_hit_r;
`ifdef PADDLE_OUTLINE_EN
      r_edge_l1 <= on_rim(hcount_in, LX0, LX1, vcount_in, w_center_l);
      r_edge_r1 <= on_rim(hcount_in, RX0, RX1, vcount_in, w_center_r);
`endif
    end
  end

  rgb_t w_rgb;

  always_comb begin
    w_rgb = r_rgb1;
    if (r_hblnk1 | r_vblnk1) begin
      w_rgb = BLACK;
    end else if (r_hit_l1) begin
`ifdef PADDLE_OUTLINE_EN
      w_rgb = r_edge_l1 ? WHITE : COLOR_L;
`else
      w_rgb = COLOR_L;
`endif
    end else if (r_hit_r1) begin
`ifdef PADDLE_OUTLINE_EN
      w_rgb = r_edge_r1 ? WHITE : COLOR_R;
`else
      w_rgb = COLOR_R;
`endif
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= BLACK;
    end else begin
      hcount_out <= r_hcount1;
      vcount_out <= r_vcount1;
      hsync_out  <= r_hsync1;
      hblnk_out  <= r_hblnk1;
      vsync_out  <= r_vsync1;
      vblnk_out  <= r_vblnk1;
      rgb_out    <= w_rgb;
    end
  end

  // Unused helper in the solid-colour build is still referenced to keep it compiled.
  logic w_unused_rim;
  assign w_unused_rim = on_rim(11'd0, LX0, LX1, 11'd0, 11'd0);

endmodule

// File: tb/tb_draw_paddles.sv
// Randomized bench for draw_paddles with a frame-level behavioural model and per-cycle compare.
module tb_draw_paddles;

  localparam logic [11:0] CL = 12'hF00;
  localparam logic [11:0] CR = 12'h00F;
`ifdef PADDLE_OUTLINE_EN
  localparam bit OUTLINE = 1'b1;
`else
  localparam bit OUTLINE = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0, pos_l = 11'd384, pos_r = 11'd384;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] hcount_out, vcount_out, center_l, center_r;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_paddles dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .pos_l(pos_l), .pos_r(pos_r),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .center_l(center_l), .center_r(center_r)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [10:0] h;
    logic        hs;
    logic        hb;
    logic [10:0] v;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } pix_t;

  pix_t m1, m2;
  int   mcl, mcr;
  bit   mprev, mseen;

  function automatic int slew(input int c, input int p);
    int t;
    t = (p < 50) ? 50 : ((p > 717) ? 717 : p);
    if (t > c + 8) return c + 8;
    if (t < c - 8) return c - 8;
    return t;
  endfunction

  function automatic logic [11:0] shade(input int h, input int v, input bit blank,
                                        input logic [11:0] bg, input int cl, input int cr);
    bit inl, inr, rl, rr;
    inl = h >= 8 && h <= 17 && v >= cl - 50 && v <= cl + 50;
    inr = h >= 1006 && h <= 1015 && v >= cr - 50 && v <= cr + 50;
    rl  = h == 8 || h == 17 || v == cl - 50 || v == cl + 50;
    rr  = h == 1006 || h == 1015 || v == cr - 50 || v == cr + 50;
    if (blank) return 12'h000;
    if (inl) return (OUTLINE && rl) ? 12'hFFF : CL;
    if (inr) return (OUTLINE && rr) ? 12'hFFF : CR;
    return bg;
  endfunction

  function automatic pix_t sample(input int cl, input int cr);
    pix_t p;
    p.h   = hcount_in;
    p.hs  = hsync_in;
    p.hb  = hblnk_in;
    p.v   = vcount_in;
    p.vs  = vsync_in;
    p.vb  = vblnk_in;
    p.rgb = shade(int'(hcount_in), int'(vcount_in), hblnk_in | vblnk_in, rgb_in, cl, cr);
    return p;
  endfunction

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      m1    <= '0;
      m2    <= '0;
      mcl   <= 384;
      mcr   <= 384;
      mprev <= 1'b0;
      mseen <= 1'b0;
    end else begin
      m2    <= m1;
      m1    <= sample(mcl, mcr);
      // Frame update: first vblank cycle, once vblank has been seen low since reset.
      if (vblnk_in && !mprev && mseen) begin
        mcl <= slew(mcl, int'(pos_l));
        mcr <= slew(mcr, int'(pos_r));
      end
      mseen <= mseen | ~vblnk_in;
      mprev <= vblnk_in;
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      check("rgb_out", 64'(rgb_out), 64'(m2.rgb));
      check("timing_out", 64'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out,
                               vblnk_out}),
            64'({m2.h, m2.hs, m2.hb, m2.v, m2.vs, m2.vb}));
      check("center_l", 64'(center_l), 64'(mcl));
      check("center_r", 64'(center_r), 64'(mcr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic pix(input int h, input int v, input bit hb, input bit vb,
                     input logic [11:0] bg);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = bg;
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
    @(posedge pclk);
    #1;
  endtask

  task automatic rand_pix(input bit vb);
    int h, v, sel;
    sel = $urandom_range(0, 2);
    h = (sel == 0) ? $urandom_range(0, 1023) :
        (sel == 1) ? $urandom_range(5, 20) : $urandom_range(1003, 1018);
    sel = $urandom_range(0, 3);
    v = (sel == 0) ? $urandom_range(0, 2047) :
        (sel == 1) ? mcl - 55 + $urandom_range(0, 110) :
        (sel == 2) ? mcr - 55 + $urandom_range(0, 110) : $urandom_range(0, 767);
    if (v < 0) v = 0;
    pix(h, v, $urandom_range(0, 7) == 0, vb, 12'($urandom));
  endtask

  task automatic frame(input int len, input bit wiggle);
    for (int i = 0; i < 4; i++) rand_pix(1'b1);
    for (int i = 0; i < len; i++) begin
      if (wiggle && $urandom_range(0, 15) == 0) begin
        pos_l = 11'($urandom_range(0, 2047));
        pos_r = 11'($urandom_range(0, 800));
      end
      rand_pix(1'b0);
    end
  endtask

  task automatic probe(input string name, input int h, input int v, input logic [11:0] bg,
                       input logic [11:0] exp);
    pix(h, v, 1'b0, 1'b0, bg);
    pix(500, 300, 1'b0, 1'b0, 12'h000);
    check(name, 64'(rgb_out), 64'(exp));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    chk_en = 1'b1;
    check("reset_rgb", 64'(rgb_out), 64'h0);
    check("reset_center_l", 64'(center_l), 64'd384);
    rst = 1'b0;

    pos_l = 11'd384;
    pos_r = 11'd384;
    frame(20, 1'b0);
    check("lit_center_l_384", 64'(center_l), 64'd384);
    check("lit_center_r_384", 64'(center_r), 64'd384);
    probe("lit_left_h8", 8, 384, 12'h123, OUTLINE ? 12'hFFF : CL);
    probe("lit_left_h12", 12, 384, 12'h123, CL);
    probe("lit_right_h1010", 1010, 384, 12'h456, CR);
    probe("lit_bg_abc", 500, 384, 12'hABC, 12'hABC);
    pix(8, 384, 1'b1, 1'b0, 12'h777);
    pix(500, 300, 1'b0, 1'b0, 12'h000);
    check("lit_blank_h8", 64'(rgb_out), 64'h0);

    pos_l = 11'd0;
    pos_r = 11'd767;
    for (int f = 0; f < 45; f++) frame(10, 1'b0);
    check("lit_center_l_50", 64'(center_l), 64'd50);
    check("lit_center_r_717", 64'(center_r), 64'd717);
    probe("lit_left_v0", 8, 0, 12'h321, OUTLINE ? 12'hFFF : CL);
    probe("lit_left_v2040", 12, 2040, 12'h321, 12'h321);
    probe("lit_right_v767", 1010, 767, 12'h654, OUTLINE ? 12'hFFF : CR);
    probe("lit_right_v665", 1010, 665, 12'h654, 12'h654);

    pos_l = 11'd200;
    frame(10, 1'b0);
    check("lit_slew_58", 64'(center_l), 64'd58);
    pos_l = 11'd600;
    for (int i = 0; i < 10; i++) rand_pix(1'b0);
    pos_l = 11'd200;
    for (int i = 0; i < 10; i++) rand_pix(1'b0);
    check("lit_midframe_hold", 64'(center_l), 64'd58);
    pos_l = 11'd600;
    frame(10, 1'b0);
    check("lit_slew_66", 64'(center_l), 64'd66);

    // Reset released inside vblank: no update until the next rising edge.
    vblnk_in = 1'b1;
    rst = 1'b1;
    @(posedge pclk);
    #1;
    rst = 1'b0;
    pos_l = 11'd100;
    for (int i = 0; i < 6; i++) rand_pix(1'b1);
    check("lit_no_pulse_after_rst", 64'(center_l), 64'd384);
    for (int i = 0; i < 3; i++) rand_pix(1'b0);
    frame(5, 1'b0);
    check("lit_first_pulse", 64'(center_l), 64'd376);

    for (int f = 0; f < 30; f++) frame($urandom_range(50, 200), 1'b1);

    // Asynchronous reset in mid-frame.
    #2;
    rst = 1'b1;
    #1;
    check("lit_async_rgb", 64'(rgb_out), 64'h0);
    check("lit_async_center", 64'(center_r), 64'd384);
    @(posedge pclk);
    #1;
    rst = 1'b0;
    for (int f = 0; f < 10; f++) frame($urandom_range(50, 150), 1'b1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
